// File: rtl/uart_rx_fifo.sv
// RX character FIFO for the 16550 path: FWFT head, overrun/error/trigger status.
// Optional character-timeout counter is built when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo #(
  parameter int DEPTH          = 16,
  parameter int AW             = 4,
  parameter int TIMEOUT_PULSES = 640
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pe_in,
  input  logic          fe_in,
  input  logic          bi_in,
  input  logic          pop,
  input  logic          baud_pulse,
  input  logic [1:0]    rx_trig,
  input  logic          overrun_clr,
  output logic [7:0]    dout,
  output logic          pe_out,
  output logic          fe_out,
  output logic          bi_out,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  output logic          err_in_fifo,
  output logic          trig_hit,
  output logic          timeout
);

  typedef struct packed {
    logic       bi;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] rp, wp;
  logic [AW:0]   err_cnt;
  logic          do_push, do_pop, ovr_set, in_err, head_err;
  logic [4:0]    lvl;

  assign head     = mem[rp];
  assign dout     = head.data;
  assign pe_out   = head.pe;
  assign fe_out   = head.fe;
  assign bi_out   = head.bi;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign in_err   = pe_in | fe_in | bi_in;
  assign head_err = head.pe | head.fe | head.bi;

  // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign ovr_set = push & full & ~pop & ~clr;

  always_comb begin
    lvl = 5'd1;
    case (rx_trig)
      2'b00: lvl = 5'd1;
      2'b01: lvl = 5'd4;
      2'b10: lvl = 5'd8;
      2'b11: lvl = 5'd14;
      default: lvl = 5'd1;
    endcase
  end
  assign trig_hit    = (32'(count) >= 32'(lvl));
  assign err_in_fifo = (err_cnt != '0);

  always_ff @(posedge clk) begin
    if (do_push && !rst && !clr)
      mem[wp] <= '{bi: bi_in, fe: fe_in, pe: pe_in, data: din};
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rp      <= '0;
      wp      <= '0;
      count   <= '0;
      err_cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      case ({do_push & in_err, do_pop & head_err})
        2'b10:   err_cnt <= err_cnt + 1'b1;
        2'b01:   err_cnt <= err_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Set beats a coincident LSR read so a fresh overrun is never lost.
  always_ff @(posedge clk) begin
    if (rst)              overrun <= 1'b0;
    else if (ovr_set)     overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [9:0] idle_cnt;
  logic       to_q;

  always_ff @(posedge clk) begin
    if (rst || clr || do_push || do_pop) begin
      idle_cnt <= '0;
      to_q     <= 1'b0;
    end else if (empty) begin
      idle_cnt <= '0;
    end else if (baud_pulse && idle_cnt != 10'(TIMEOUT_PULSES)) begin
      idle_cnt <= idle_cnt + 1'b1;
      if (idle_cnt == 10'(TIMEOUT_PULSES - 1)) to_q <= 1'b1;
    end
  end
  assign timeout = to_q;
`else
  logic unused_baud;
  assign unused_baud = baud_pulse;
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed plan plus random traffic
// compared each cycle against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int TP    = 640;

  logic        clk = 1'b0;
  logic        rst, clr, push, pe_in, fe_in, bi_in, pop, baud_pulse, overrun_clr;
  logic [7:0]  din;
  logic [1:0]  rx_trig;
  logic [7:0]  dout;
  logic        pe_out, fe_out, bi_out, empty, full, overrun, err_in_fifo, trig_hit, timeout;
  logic [AW:0] count;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT_PULSES(TP)) dut (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .din(din),
    .pe_in(pe_in), .fe_in(fe_in), .bi_in(bi_in), .pop(pop),
    .baud_pulse(baud_pulse), .rx_trig(rx_trig), .overrun_clr(overrun_clr),
    .dout(dout), .pe_out(pe_out), .fe_out(fe_out), .bi_out(bi_out),
    .empty(empty), .full(full), .count(count), .overrun(overrun),
    .err_in_fifo(err_in_fifo), .trig_hit(trig_hit), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [10:0] q[$];
  bit          m_ovr;
  int          m_idle;
  bit          m_to;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lvl_of(input logic [1:0] t);
    case (t)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 14;
    endcase
  endfunction

  task automatic check_all();
    bit any_err = 0;
    foreach (q[i]) if (q[i][10:8] != 3'b000) any_err = 1;
    chk("count",   32'(count),       32'(q.size()));
    chk("empty",   32'(empty),       32'(q.size() == 0));
    chk("full",    32'(full),        32'(q.size() == DEPTH));
    chk("overrun", 32'(overrun),     32'(m_ovr));
    chk("err",     32'(err_in_fifo), 32'(any_err));
    chk("trig",    32'(trig_hit),    32'(q.size() >= lvl_of(rx_trig)));
    chk("timeout", 32'(timeout),     32'(m_to));
    if (q.size() > 0)
      chk("head", 32'({bi_out, fe_out, pe_out, dout}), 32'(q[0]));
  endtask

  // One clock of stimulus; the model is advanced from the pre-edge state.
  task automatic cyc(input bit p, input logic [10:0] e, input bit po,
                     input bit c = 0, input bit oc = 0, input bit bp = 0);
    bit ne  = (q.size() > 0);
    bit acc = 0;
    push = p; {bi_in, fe_in, pe_in, din} = e; pop = po;
    clr = c; overrun_clr = oc; baud_pulse = bp;
    if (oc) m_ovr = 0;
    if (c) begin
      q.delete(); m_idle = 0; m_to = 0;
    end else begin
      if (po && ne) begin
        void'(q.pop_front()); acc = 1;
        if (p) q.push_back(e);
      end else if (p) begin
        if (q.size() < DEPTH) begin q.push_back(e); acc = 1; end
        else m_ovr = 1;
      end
`ifdef UART_RX_FIFO_TIMEOUT_EN
      if (acc) begin m_idle = 0; m_to = 0; end
      else if (!ne) m_idle = 0;
      else if (bp && m_idle < TP) begin
        m_idle++;
        if (m_idle == TP) m_to = 1;
      end
`endif
    end
    @(posedge clk); #1;
    push = 0; pop = 0; clr = 0; overrun_clr = 0; baud_pulse = 0;
    check_all();
  endtask

  task automatic do_rst();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    q.delete(); m_ovr = 0; m_idle = 0; m_to = 0;
    check_all();
  endtask

  initial begin
    rst = 0; clr = 0; push = 0; pop = 0; baud_pulse = 0; overrun_clr = 0;
    din = '0; pe_in = 0; fe_in = 0; bi_in = 0; rx_trig = 2'b00;
    repeat (2) @(posedge clk);
    do_rst();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_trig",  32'(trig_hit), 32'd0);

    // basic push/pop, pop on empty
    cyc(1, 11'h0A5, 0);
    cyc(1, 11'h03C, 0);
    chk("t1_cnt",  32'(count), 32'd2);
    chk("t1_head", 32'(dout), 32'hA5);
    cyc(0, 0, 1);
    chk("t1_head2", 32'(dout), 32'h3C);
    cyc(0, 0, 1);
    chk("t1_empty", 32'(empty), 32'd1);
    cyc(0, 0, 1);
    chk("t1_extra", 32'(count), 32'd0);

    // fill, overrun, drain in order
    for (int i = 0; i < 16; i++) cyc(1, 11'(i), 0);
    chk("t2_full", 32'(full), 32'd1);
    cyc(1, 11'h0FF, 0);
    chk("t2_ovr", 32'(overrun), 32'd1);
    chk("t2_cnt", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("t2_order", 32'(dout), 32'(i));
      cyc(0, 0, 1);
    end
    cyc(0, 0, 0, 0, 1);
    chk("t2_ovr_clr", 32'(overrun), 32'd0);

    // push+pop on full, then wrap
    for (int i = 0; i < 16; i++) cyc(1, 11'(8'h40 + i), 0);
    cyc(1, 11'h077, 1);
    chk("t3_cnt", 32'(count), 32'd16);
    chk("t3_ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("t3_last", 32'(dout), 32'h77);
      cyc(0, 0, 1);
    end
    for (int j = 0; j < 20; j++) cyc(1, 11'(8'h80 + j), 1);
    cyc(0, 0, 1);

    // error tracking
    cyc(1, 11'h211, 0);
    cyc(1, 11'h022, 0);
    chk("t4_err", 32'(err_in_fifo), 32'd1);
    chk("t4_fe",  32'(fe_out), 32'd1);
    cyc(0, 0, 1);
    chk("t4_err_clr", 32'(err_in_fifo), 32'd0);
    cyc(0, 0, 1);

    // trigger level 8, then clr with push keeps overrun
    rx_trig = 2'b10;
    for (int i = 0; i < 7; i++) cyc(1, 11'(i), 0);
    chk("t5_trig7", 32'(trig_hit), 32'd0);
    cyc(1, 11'h007, 0);
    chk("t5_trig8", 32'(trig_hit), 32'd1);
    for (int i = 0; i < 9; i++) cyc(1, 11'(i), 0);
    chk("t5_ovr", 32'(overrun), 32'd1);
    cyc(1, 11'h055, 0, 1);
    chk("t5_clr_cnt",  32'(count), 32'd0);
    chk("t5_clr_trig", 32'(trig_hit), 32'd0);
    chk("t5_clr_ovr",  32'(overrun), 32'd1);
    cyc(0, 0, 0, 0, 1);

    // character timeout
    rx_trig = 2'b00;
    cyc(1, 11'h0C3, 0);
    for (int i = 0; i < TP - 1; i++) cyc(0, 0, 0, 0, 0, 1);
    chk("t6_to639", 32'(timeout), 32'd0);
    cyc(0, 0, 0, 0, 0, 1);
`ifdef UART_RX_FIFO_TIMEOUT_EN
    chk("t6_to640", 32'(timeout), 32'd1);
`else
    chk("t6_to640", 32'(timeout), 32'd0);
`endif
    cyc(0, 0, 1);
    chk("t6_to_pop", 32'(timeout), 32'd0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [10:0] e;
      e[7:0]  = 8'($urandom);
      e[10:8] = ($urandom_range(3) == 0) ? 3'($urandom) : 3'b000;
      rx_trig = 2'($urandom);
      if ($urandom_range(499) == 0) do_rst();
      else cyc(bit'($urandom_range(1)), e, bit'($urandom_range(2) == 0),
               $urandom_range(63) == 0, $urandom_range(15) == 0,
               bit'($urandom_range(1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
